// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multi-cycle MIPS core: PC, IR and req/ack handshake to instruction memory.
// Define FETCH_ALIGN_CHECK_EN to reject misaligned redirects and raise a sticky addr_err.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        ir_write,
    input  logic        if_beq,
    input  logic        if_j,
    input  logic        if_jr,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_stall,
    output logic        addr_err
);

    typedef enum logic [0:0] {StIdle, StFetch} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] addr_q, addr_d;
    logic        inc_q, inc_d;

    logic        redir_take;
    logic [31:0] redir_target;
    logic [31:0] br_offset;
    logic        redir_en;
    logic        redir_load;
    logic [31:0] redir_pc;

    assign br_offset = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    // Qualifier priority: jr over j over beq; beq only counts when taken.
    always_comb begin
        redir_take   = 1'b1;
        redir_target = pc_q;
        if (if_jr) begin
            redir_target = rs_data;
        end else if (if_j) begin
            redir_target = {pc_q[31:28], ir_q[25:0], 2'b00};
        end else if (if_beq && zero) begin
            redir_target = pc_q + br_offset;
        end else begin
            redir_take = 1'b0;
        end
    end

    assign redir_en = (state_q == StIdle) && pc_write && !ir_write && redir_take;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    logic err_q;

    assign misaligned = |redir_target[1:0];
    assign redir_pc   = redir_target;
    assign redir_load = redir_en && !misaligned;
    assign addr_err   = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (redir_en && misaligned) begin
            err_q <= 1'b1;
        end
    end
`else
    assign redir_pc   = redir_target & ~32'h3;
    assign redir_load = redir_en;
    assign addr_err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        inc_d   = inc_q;
        unique case (state_q)
            StIdle: begin
                if (ir_write) begin
                    state_d = StFetch;
                    addr_d  = {pc_q[31:2], 2'b00};
                    inc_d   = pc_write;
                end else if (redir_load) begin
                    pc_d = redir_pc;
                end
            end
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = StIdle;
                    if (inc_q) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INS;
            addr_q  <= RESET_PC;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            inc_q   <= inc_d;
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign imem_addr   = addr_q;
    assign ins         = ir_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fetch_stall = (state_q == StFetch) || ((state_q == StIdle) && ir_write);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed table, hand sequences and a random
// transaction stream checked against a transaction-level model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_write = 1'b0;
    logic        ir_write = 1'b0;
    logic        if_beq = 1'b0;
    logic        if_j = 1'b0;
    logic        if_jr = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] rs_data = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_stall;
    logic        addr_err;

    int total = 0;
    int bad = 0;

    // Reference state: architectural PC, IR and the sticky error flag.
    logic [31:0] m_pc = 32'h0000_3000;
    logic [31:0] m_ins = 32'h0;
    logic        m_err = 1'b0;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .if_beq      (if_beq),
        .if_j        (if_j),
        .if_jr       (if_jr),
        .zero        (zero),
        .rs_data     (rs_data),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ins         (ins),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_stall (fetch_stall),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc0;
        logic [31:0] ins;
        logic        jr;
        logic        j;
        logic        beq;
        logic        z;
        logic [31:0] rs;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_redirect(input logic jr, input logic j, input logic beq, input logic z,
                                  input logic [31:0] rs);
        logic [31:0] t;
        int          off;
        bit          take;
        take = 1'b1;
        t    = m_pc;
        off  = int'(m_ins[15:0]);
        if (off >= 32768) off = off - 65536;
        if (jr) t = rs;
        else if (j) t = (m_pc & 32'hF000_0000) | ((m_ins & 32'h03FF_FFFF) * 4);
        else if (beq && z) t = m_pc + 32'(off * 4);
        else take = 1'b0;
        if (take) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (t % 4 != 0) m_err = 1'b1;
            else m_pc = t;
`else
            m_pc = t - (t % 4);
`endif
        end
    endtask

    task automatic do_fetch(input logic pw, input int w, input logic [31:0] data,
                            input logic noise, output int stalls);
        logic [31:0] exp_addr;
        logic [31:0] old_ins;
        exp_addr = m_pc;
        old_ins  = m_ins;
        stalls   = 0;
        ir_write = 1'b1;
        pc_write = pw;
        if (noise) begin
            if_jr  = 1'($urandom);
            if_j   = 1'($urandom);
            if_beq = 1'($urandom);
            zero   = 1'($urandom);
        end
        #1;
        check("stall_on_irw", {31'b0, fetch_stall}, 32'd1);
        check("req_before_fetch", {31'b0, imem_req}, 32'd0);
        if (fetch_stall) stalls++;
        tick();
        ir_write = 1'b0;
        pc_write = 1'b0;
        for (int i = 0; i <= w; i++) begin
            imem_ack   = (i == w);
            imem_rdata = (i == w) ? data : $urandom;
            if (noise) begin
                pc_write = 1'($urandom);
                ir_write = 1'($urandom);
            end
            #1;
            check("req_in_fetch", {31'b0, imem_req}, 32'd1);
            check("addr_stable", imem_addr, exp_addr);
            check("ins_hold", ins, old_ins);
            if (fetch_stall) stalls++;
            tick();
        end
        imem_ack = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        if_jr    = 1'b0;
        if_j     = 1'b0;
        if_beq   = 1'b0;
        m_ins    = data;
        if (pw) m_pc = m_pc + 32'd4;
        #1;
        check("req_drop", {31'b0, imem_req}, 32'd0);
        check("stall_drop", {31'b0, fetch_stall}, 32'd0);
        check("ins_after_fetch", ins, m_ins);
        check("pc_after_fetch", pc, m_pc);
        check("stall_cycles", 32'(stalls), 32'(w + 2));
    endtask

    task automatic do_redirect(input logic jr, input logic j, input logic beq, input logic z,
                               input logic [31:0] rs, input logic ack_noise);
        ir_write   = 1'b0;
        pc_write   = 1'b1;
        if_jr      = jr;
        if_j       = j;
        if_beq     = beq;
        zero       = z;
        rs_data    = rs;
        imem_ack   = ack_noise;
        imem_rdata = $urandom;
        #1;
        check("redir_no_stall", {31'b0, fetch_stall}, 32'd0);
        tick();
        pc_write = 1'b0;
        if_jr    = 1'b0;
        if_j     = 1'b0;
        if_beq   = 1'b0;
        imem_ack = 1'b0;
        model_redirect(jr, j, beq, z, rs);
        #1;
        check("redir_pc", pc, m_pc);
        check("redir_pc_plus4", pc_plus4, m_pc + 32'd4);
        check("redir_addr_err", {31'b0, addr_err}, {31'b0, m_err});
        check("redir_ins_hold", ins, m_ins);
        check("redir_no_req", {31'b0, imem_req}, 32'd0);
    endtask

    initial begin
        int st;
        vecs[0] = '{32'h0000_3008, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_3000};
        vecs[1] = '{32'h0000_3008, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_3008};
        vecs[2] = '{32'h0000_3004, 32'h0800_0C10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_3040};
        vecs[3] = '{32'h0000_3004, 32'h0800_0C10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3010, 32'h0000_3010};
        vecs[4] = '{32'h0000_3020, 32'h0800_0C10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_3020};
        vecs[5] = '{32'h0000_3004, 32'h0800_0C10, 1'b1, 1'b1, 1'b1, 1'b1, 32'h4000, 32'h0000_4000};
        vecs[6] = '{32'h0000_3008, 32'h1000_0004, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_0010};
        vecs[7] = '{32'hFFFF_FFFC, 32'h1000_0001, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0000};
        vecs[8] = '{32'hA000_0000, 32'h03FF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hAFFF_FFFC};

        // Reset held low, then released.
        #2 reset = 1'b0;
        tick();
        tick();
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_ins", ins, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_stall", {31'b0, fetch_stall}, 32'd0);
        check("rst_err", {31'b0, addr_err}, 32'd0);
        reset = 1'b1;
        tick();
        check("post_rst_pc", pc, 32'h0000_3000);
        check("post_rst_pc_plus4", pc_plus4, 32'h0000_3004);

        // Zero-wait fetch, then a fetch with two wait cycles and pc_write noise.
        do_fetch(1'b1, 0, 32'h3C01_1234, 1'b0, st);
        check("zw_ins", ins, 32'h3C01_1234);
        check("zw_pc", pc, 32'h0000_3004);
        check("zw_stalls", 32'(st), 32'd2);
        do_fetch(1'b1, 2, 32'h2402_0005, 1'b1, st);
        check("ws_pc", pc, 32'h0000_3008);
        check("ws_stalls", 32'(st), 32'd4);

        // Table: set PC via jr, load IR without incrementing, then apply the redirect.
        foreach (vecs[k]) begin
            do_redirect(1'b1, 1'b0, 1'b0, 1'b0, vecs[k].pc0, 1'b0);
            do_fetch(1'b0, k % 3, vecs[k].ins, 1'b0, st);
            do_redirect(vecs[k].jr, vecs[k].j, vecs[k].beq, vecs[k].z, vecs[k].rs, 1'b0);
            check($sformatf("vec%0d_pc", k), pc, vecs[k].exp_pc);
        end
        check("jal_link", pc_plus4, 32'hAFFF_FFFC + 32'd4);

        // Reset asserted mid-fetch: request drops at once and a late ack is ignored.
        ir_write = 1'b1;
        pc_write = 1'b1;
        tick();
        ir_write = 1'b0;
        pc_write = 1'b0;
        #1;
        check("mid_req_before", {31'b0, imem_req}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_req_async", {31'b0, imem_req}, 32'd0);
        check("mid_pc_async", pc, 32'h0000_3000);
        check("mid_ins_async", ins, 32'h0);
        check("mid_stall_async", {31'b0, fetch_stall}, 32'd0);
        #1 reset = 1'b1;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("late_ack_req", {31'b0, imem_req}, 32'd0);
        tick();
        imem_ack = 1'b0;
        #1;
        check("late_ack_ins", ins, 32'h0);
        check("late_ack_pc", pc, 32'h0000_3000);
        m_pc  = 32'h0000_3000;
        m_ins = 32'h0;
        m_err = 1'b0;

        // Misaligned jr.
        do_redirect(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3011, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_pc", pc, 32'h0000_3000);
        check("mis_err", {31'b0, addr_err}, 32'd1);
`else
        check("mis_pc", pc, 32'h0000_3010);
        check("mis_err", {31'b0, addr_err}, 32'd0);
`endif
        do_redirect(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 1'b0);

        // Random transaction stream.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_redirect(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                            ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h3),
                            1'($urandom));
            end else begin
                do_fetch(1'($urandom), $urandom_range(0, 3), $urandom, 1'b1, st);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
